mem_wb: RTL and testbench

- Pipeline register between the memory-access stage and the register-file write port.
- Captures mem-stage outputs each cycle and formats raw load words into RV32I load results (LB/LH/LW/LBU/LHU): byte/half select, sign/zero extension.
- Presents the final write-back triple to the register file and the forwarding unit.
- Keeps a 64-bit retired-instruction counter and flags misaligned loads.

---
 rtl/mem_wb_pkg.sv | 30 +++
 rtl/mem_wb_load_fmt.sv | 58 +++++
 rtl/mem_wb.sv | 123 ++++++++++++
 tb/tb_mem_wb.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_pkg
// Shared widths, reset level, RV32I load funct3 codes and the NOP encoding
// used by the MEM/WB pipeline register and its load formatter.
// -----------------------------------------------------------------------------
package mem_wb_pkg;

  // Datapath widths
  localparam int INST_W     = 32;  // instruction word
  localparam int MEM_W      = 32;  // raw data-memory word
  localparam int MEM_ADDR_W = 32;  // data-memory byte address
  localparam int REG_W      = 32;  // register-file data
  localparam int REG_ADDR_W = 5;   // register-file address

  // Level of arst_n at which the design is held in reset.
  localparam logic RST_ENABLE = 1'b0;

  // addi x0, x0, 0 -- the canonical bubble.
  localparam logic [INST_W-1:0] NOP_ENC = 32'h0000_0013;

  // RV32I load funct3 encodings (inst[14:12]).
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

endpackage : mem_wb_pkg

// File: rtl/mem_wb_load_fmt.sv
// -----------------------------------------------------------------------------
// load_fmt
// Purely combinational RV32I load formatter. Selects the addressed byte or
// halfword out of the aligned 32-bit memory word and sign/zero extends it.
//
// Ports:
//   funct3   in   load width/sign code (inst[14:12])
//   off      in   byte offset within the word (addr[1:0])
//   raw      in   aligned 32-bit word from data memory
//   data     out  formatted load result (0 when misaligned or illegal)
//   misalign out  halfword at odd offset, or word at non-zero offset
//   illegal  out  funct3 is not a load encoding
// -----------------------------------------------------------------------------
module load_fmt
  import mem_wb_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [1:0]       off,
  input  logic [MEM_W-1:0] raw,
  output logic [REG_W-1:0] data,
  output logic             misalign,
  output logic             illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte lane chosen by the full offset; halfword lane by off[1] only, since
  // odd offsets for halfwords are rejected as misaligned below.
  assign byte_sel = raw[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? raw[31:16] : raw[15:0];

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    data     = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'h0, byte_sel};
      F3_LH: begin
        if (off[0]) misalign = 1'b1;
        else        data     = {{16{half_sel[15]}}, half_sel};
      end
      F3_LHU: begin
        if (off[0]) misalign = 1'b1;
        else        data     = {16'h0, half_sel};
      end
      F3_LW: begin
        if (off != 2'b00) misalign = 1'b1;
        else              data     = raw;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule : load_fmt

// File: rtl/mem_wb.sv
// -----------------------------------------------------------------------------
// mem_wb
// MEM -> WB pipeline register. Captures the memory-stage result each cycle,
// formats load data, and presents the write-back triple to the register file
// and forwarding unit. Also counts retired (non-bubble) instructions and flags
// misaligned loads.
//
// Ports:
//   clk             in   system clock, rising edge
//   arst_n          in   asynchronous active-low reset
//   stall_i         in   hold every register, including the retire counter
//   flush_i         in   load a bubble (wins over stall_i)
//   inst_i          in   instruction from the mem stage
//   mem_r_ena_i     in   instruction is a load
//   mem_r_data_i    in   raw aligned word from data memory
//   mem_r_addr_i    in   byte address of the load
//   reg_w_ena_i     in   write-back enable
//   reg_w_data_i    in   ALU result for non-load instructions
//   reg_w_addr_i    in   destination register
//   inst_o          out  registered instruction
//   reg_w_ena_o     out  register-file write enable
//   reg_w_addr_o    out  register-file write address
//   reg_w_data_o    out  formatted write data
//   load_misalign_o out  registered misaligned-load flag
//   retire_cnt_o    out  count of non-bubble instructions retired
// -----------------------------------------------------------------------------
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = NOP_ENC,
  parameter int                CNT_W    = 64
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [INST_W-1:0]     inst_i,
  input  logic                  mem_r_ena_i,
  input  logic [MEM_W-1:0]      mem_r_data_i,
  input  logic [MEM_ADDR_W-1:0] mem_r_addr_i,
  input  logic                  reg_w_ena_i,
  input  logic [REG_W-1:0]      reg_w_data_i,
  input  logic [REG_ADDR_W-1:0] reg_w_addr_i,
  output logic [INST_W-1:0]     inst_o,
  output logic                  reg_w_ena_o,
  output logic [REG_ADDR_W-1:0] reg_w_addr_o,
  output logic [REG_W-1:0]      reg_w_data_o,
  output logic                  load_misalign_o,
  output logic [CNT_W-1:0]      retire_cnt_o
);

  // ---------------------------------------------------------------------------
  // Load formatting (ahead of the register)
  // ---------------------------------------------------------------------------
  logic [REG_W-1:0] fmt_data;
  logic             fmt_misalign;
  logic             fmt_illegal;

  load_fmt u_load_fmt (
    .funct3   (inst_i[14:12]),
    .off      (mem_r_addr_i[1:0]),
    .raw      (mem_r_data_i),
    .data     (fmt_data),
    .misalign (fmt_misalign),
    .illegal  (fmt_illegal)
  );

  // Only the byte offset matters here; the word address was already used to
  // fetch mem_r_data_i.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_r_addr_i[MEM_ADDR_W-1:2];

  // ---------------------------------------------------------------------------
  // Next-entry values
  // ---------------------------------------------------------------------------
  logic             load_fault;
  logic             wb_ena_d;
  logic [REG_W-1:0] wb_data_d;
  logic             misalign_d;

  always_comb begin
    load_fault = mem_r_ena_i & (fmt_misalign | fmt_illegal);
    misalign_d = mem_r_ena_i & fmt_misalign;
    // fmt_data is already zero on a faulting load.
    wb_data_d  = mem_r_ena_i ? fmt_data : reg_w_data_i;
    // Writes to x0 are dropped here so the forwarding unit never sees them.
    wb_ena_d   = reg_w_ena_i & (reg_w_addr_i != '0) & ~load_fault;
  end

  // ---------------------------------------------------------------------------
  // Pipeline register and retire counter
  // Priority: reset > flush > stall > capture.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (arst_n == RST_ENABLE) begin
      inst_o          <= NOP_INST;
      reg_w_ena_o     <= 1'b0;
      reg_w_addr_o    <= '0;
      reg_w_data_o    <= '0;
      load_misalign_o <= 1'b0;
      retire_cnt_o    <= '0;
    end else if (flush_i) begin
      inst_o          <= NOP_INST;
      reg_w_ena_o     <= 1'b0;
      reg_w_addr_o    <= '0;
      reg_w_data_o    <= '0;
      load_misalign_o <= 1'b0;
    end else if (!stall_i) begin
      inst_o          <= inst_i;
      reg_w_ena_o     <= wb_ena_d;
      reg_w_addr_o    <= reg_w_addr_i;
      reg_w_data_o    <= wb_data_d;
      load_misalign_o <= misalign_d;
      // Misaligned loads still retire (they are reported, not squashed).
      if (inst_i != NOP_INST) begin
        retire_cnt_o <= retire_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule : mem_wb

// File: tb/tb_mem_wb.sv
// -----------------------------------------------------------------------------
// tb_mem_wb
// Self-checking bench for mem_wb: directed vector table, hand-written
// multi-cycle sequences (async reset, stall/flush, counter wrap) and a
// randomized run against a behavioural model. A second instance with a
// 4-bit retire counter shares all inputs to exercise wrap-around.
// -----------------------------------------------------------------------------
module tb_mem_wb;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        stall_i, flush_i;
  logic [31:0] inst_i;
  logic        mem_r_ena_i;
  logic [31:0] mem_r_data_i, mem_r_addr_i;
  logic        reg_w_ena_i;
  logic [31:0] reg_w_data_i;
  logic [4:0]  reg_w_addr_i;

  logic [31:0] inst_o;
  logic        reg_w_ena_o;
  logic [4:0]  reg_w_addr_o;
  logic [31:0] reg_w_data_o;
  logic        load_misalign_o;
  logic [63:0] retire_cnt_o;

  logic [31:0] w_inst_o;
  logic        w_reg_w_ena_o;
  logic [4:0]  w_reg_w_addr_o;
  logic [31:0] w_reg_w_data_o;
  logic        w_load_misalign_o;
  logic [3:0]  w_retire_cnt_o;

  always #5 clk = ~clk;

  mem_wb #(.NOP_INST(NOP), .CNT_W(64)) u_dut (
    .clk(clk), .arst_n(arst_n), .stall_i(stall_i), .flush_i(flush_i),
    .inst_i(inst_i), .mem_r_ena_i(mem_r_ena_i), .mem_r_data_i(mem_r_data_i),
    .mem_r_addr_i(mem_r_addr_i), .reg_w_ena_i(reg_w_ena_i),
    .reg_w_data_i(reg_w_data_i), .reg_w_addr_i(reg_w_addr_i),
    .inst_o(inst_o), .reg_w_ena_o(reg_w_ena_o), .reg_w_addr_o(reg_w_addr_o),
    .reg_w_data_o(reg_w_data_o), .load_misalign_o(load_misalign_o),
    .retire_cnt_o(retire_cnt_o)
  );

  mem_wb #(.NOP_INST(NOP), .CNT_W(4)) u_wrap (
    .clk(clk), .arst_n(arst_n), .stall_i(stall_i), .flush_i(flush_i),
    .inst_i(inst_i), .mem_r_ena_i(mem_r_ena_i), .mem_r_data_i(mem_r_data_i),
    .mem_r_addr_i(mem_r_addr_i), .reg_w_ena_i(reg_w_ena_i),
    .reg_w_data_i(reg_w_data_i), .reg_w_addr_i(reg_w_addr_i),
    .inst_o(w_inst_o), .reg_w_ena_o(w_reg_w_ena_o),
    .reg_w_addr_o(w_reg_w_addr_o), .reg_w_data_o(w_reg_w_data_o),
    .load_misalign_o(w_load_misalign_o), .retire_cnt_o(w_retire_cnt_o)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: what the write-back stage should hold after each edge.
  // ---------------------------------------------------------------------------
  logic [31:0] m_inst;
  logic        m_ena;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_mis;
  logic [63:0] m_cnt;

  function automatic void model_reset();
    m_inst = NOP; m_ena = 1'b0; m_addr = '0; m_data = '0; m_mis = 1'b0; m_cnt = '0;
  endfunction

  // Load result from the RV32I rules: pick size bytes starting at off,
  // reject offsets not a multiple of size, sign-extend when requested.
  function automatic void ref_load(input logic [2:0] f3, input int off, input logic [31:0] raw,
                                   output logic [31:0] d, output logic mis, output logic ok);
    int     size;
    bit     sgn;
    longint mask, v;
    d = '0; mis = 1'b0; ok = 1'b0;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd4: begin size = 1; sgn = 1'b0; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd5: begin size = 2; sgn = 1'b0; end
      3'd2: begin size = 4; sgn = 1'b0; end
      default: return;
    endcase
    if (off % size != 0) begin
      mis = 1'b1;
      return;
    end
    mask = (longint'(1) << (8 * size)) - 1;
    v    = longint'({32'h0, raw} >> (8 * off)) & mask;
    if (sgn && v[8*size-1]) v = v - (mask + 1);
    d  = v[31:0];
    ok = 1'b1;
  endfunction

  task automatic model_edge();
    logic [31:0] d;
    logic        mis, ok;
    if (flush_i) begin
      m_inst = NOP; m_ena = 1'b0; m_addr = '0; m_data = '0; m_mis = 1'b0;
    end else if (!stall_i) begin
      if (mem_r_ena_i) begin
        ref_load(inst_i[14:12], int'(mem_r_addr_i % 4), mem_r_data_i, d, mis, ok);
      end else begin
        d = reg_w_data_i; mis = 1'b0; ok = 1'b1;
      end
      m_inst = inst_i;
      m_ena  = reg_w_ena_i && (reg_w_addr_i != 0) && ok;
      m_addr = reg_w_addr_i;
      m_data = d;
      m_mis  = mis;
      if (inst_i != NOP) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".inst"}, inst_o,          m_inst);
    check({tag, ".ena"},  reg_w_ena_o,     m_ena);
    check({tag, ".addr"}, reg_w_addr_o,    m_addr);
    check({tag, ".data"}, reg_w_data_o,    m_data);
    check({tag, ".mis"},  load_misalign_o, m_mis);
    check({tag, ".cnt"},  retire_cnt_o,    m_cnt);
    check({tag, ".cnt4"}, w_retire_cnt_o,  m_cnt[3:0]);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic st, input logic fl, input logic [31:0] inst,
                       input logic mre, input logic [31:0] raw, input logic [31:0] maddr,
                       input logic we, input logic [31:0] wd, input logic [4:0] wa);
    stall_i = st; flush_i = fl; inst_i = inst; mem_r_ena_i = mre;
    mem_r_data_i = raw; mem_r_addr_i = maddr;
    reg_w_ena_i = we; reg_w_data_i = wd; reg_w_addr_i = wa;
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic alu(input logic st, input logic fl, input logic [4:0] rd, input logic [31:0] wd);
    drive(st, fl, 32'h0000_0033 | (32'(rd) << 7), 1'b0, 32'h0, 32'h0, 1'b1, wd, rd);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".inst"}, inst_o,          NOP);
    check({tag, ".ena"},  reg_w_ena_o,     1'b0);
    check({tag, ".addr"}, reg_w_addr_o,    5'd0);
    check({tag, ".data"}, reg_w_data_o,    32'h0);
    check({tag, ".mis"},  load_misalign_o, 1'b0);
    check({tag, ".cnt"},  retire_cnt_o,    64'd0);
    check({tag, ".cnt4"}, w_retire_cnt_o,  4'd0);
  endtask

  // Asynchronous reset pulse placed mid-cycle, released on a falling edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state(tag);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic        stall, flush;
    logic [31:0] inst;
    logic        mre;
    logic [31:0] raw, maddr;
    logic        we;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic [31:0] e_inst;
    logic        e_ena;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Load instructions target rd=5 (inst[11:7]=5); ALU write data is junk on
    // loads so a wrong data-path select shows up.
    tbl[0]  = '{"lb_off3",   1'b0, 1'b0, 32'h0000_0283, 1'b1, 32'h80FF_7F01, 32'h0000_1003, 1'b1, 32'h1234_5678, 5'd5,
                32'h0000_0283, 1'b1, 5'd5, 32'hFFFF_FF80, 1'b0};
    tbl[1]  = '{"lbu_off3",  1'b0, 1'b0, 32'h0000_4283, 1'b1, 32'h80FF_7F01, 32'h0000_1003, 1'b1, 32'h1234_5678, 5'd5,
                32'h0000_4283, 1'b1, 5'd5, 32'h0000_0080, 1'b0};
    tbl[2]  = '{"lb_off1",   1'b0, 1'b0, 32'h0000_0283, 1'b1, 32'h80FF_7F01, 32'h0000_2001, 1'b1, 32'h1234_5678, 5'd5,
                32'h0000_0283, 1'b1, 5'd5, 32'h0000_007F, 1'b0};
    tbl[3]  = '{"lh_off2",   1'b0, 1'b0, 32'h0000_1283, 1'b1, 32'h8001_1234, 32'h0000_1002, 1'b1, 32'h1234_5678, 5'd5,
                32'h0000_1283, 1'b1, 5'd5, 32'hFFFF_8001, 1'b0};
    tbl[4]  = '{"lhu_off0",  1'b0, 1'b0, 32'h0000_5283, 1'b1, 32'h8001_1234, 32'h0000_1000, 1'b1, 32'h1234_5678, 5'd5,
                32'h0000_5283, 1'b1, 5'd5, 32'h0000_1234, 1'b0};
    tbl[5]  = '{"lw_off1",   1'b0, 1'b0, 32'h0000_2283, 1'b1, 32'h8001_1234, 32'h0000_1001, 1'b1, 32'h1234_5678, 5'd5,
                32'h0000_2283, 1'b0, 5'd5, 32'h0000_0000, 1'b1};
    tbl[6]  = '{"lw_off0",   1'b0, 1'b0, 32'h0000_2283, 1'b1, 32'h8001_1234, 32'h0000_1000, 1'b1, 32'h1234_5678, 5'd5,
                32'h0000_2283, 1'b1, 5'd5, 32'h8001_1234, 1'b0};
    tbl[7]  = '{"lhu_off1",  1'b0, 1'b0, 32'h0000_5283, 1'b1, 32'h8001_1234, 32'h0000_1001, 1'b1, 32'h1234_5678, 5'd5,
                32'h0000_5283, 1'b0, 5'd5, 32'h0000_0000, 1'b1};
    tbl[8]  = '{"ld_f3_011", 1'b0, 1'b0, 32'h0000_3283, 1'b1, 32'h8001_1234, 32'h0000_1000, 1'b1, 32'h1234_5678, 5'd5,
                32'h0000_3283, 1'b0, 5'd5, 32'h0000_0000, 1'b0};
    tbl[9]  = '{"alu_x0",    1'b0, 1'b0, 32'h0000_0033, 1'b0, 32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF, 5'd0,
                32'h0000_0033, 1'b0, 5'd0, 32'hDEAD_BEEF, 1'b0};
    tbl[10] = '{"alu_x7",    1'b0, 1'b0, 32'h0000_03B3, 1'b0, 32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF, 5'd7,
                32'h0000_03B3, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0};
    tbl[11] = '{"flush",     1'b0, 1'b1, 32'h0000_0283, 1'b1, 32'h80FF_7F01, 32'h0000_1003, 1'b1, 32'h1234_5678, 5'd5,
                NOP,           1'b0, 5'd0, 32'h0000_0000, 1'b0};
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    arst_n = 1'b0;
    drive(1'b0, 1'b0, NOP, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0);
    model_reset();
    #12;
    check_reset_state("reset");
    @(negedge clk);
    arst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].inst, tbl[i].mre, tbl[i].raw,
            tbl[i].maddr, tbl[i].we, tbl[i].wd, tbl[i].wa);
      cycle();
      check({tbl[i].name, ".inst"}, inst_o,          tbl[i].e_inst);
      check({tbl[i].name, ".ena"},  reg_w_ena_o,     tbl[i].e_ena);
      check({tbl[i].name, ".addr"}, reg_w_addr_o,    tbl[i].e_addr);
      check({tbl[i].name, ".data"}, reg_w_data_o,    tbl[i].e_data);
      check({tbl[i].name, ".mis"},  load_misalign_o, tbl[i].e_mis);
      check({tbl[i].name, ".cnt"},  retire_cnt_o,    m_cnt);
    end
    // NOP input retires nothing
    drive(1'b0, 1'b0, NOP, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0);
    cycle();
    check_model("nop");

    // Reset asserted mid-cycle while a valid entry is held
    alu(1'b0, 1'b0, 5'd9, 32'hCAFE_F00D);
    cycle();
    check("pre_rst.ena", reg_w_ena_o, 1'b1);
    async_reset("mid_rst");

    // Stall / flush sequence
    alu(1'b0, 1'b0, 5'd1, 32'h1111_1111);
    cycle();
    check("op1.data", reg_w_data_o, 32'h1111_1111);
    check("op1.cnt",  retire_cnt_o, 64'd1);
    alu(1'b1, 1'b0, 5'd2, 32'h2222_2222);
    cycle();
    check("stall.data", reg_w_data_o, 32'h1111_1111);
    check("stall.addr", reg_w_addr_o, 5'd1);
    check("stall.cnt",  retire_cnt_o, 64'd1);
    alu(1'b0, 1'b0, 5'd2, 32'h2222_2222);
    cycle();
    check("op2.data", reg_w_data_o, 32'h2222_2222);
    check("op2.cnt",  retire_cnt_o, 64'd2);
    alu(1'b0, 1'b0, 5'd3, 32'h3333_3333);
    cycle();
    check("op3.cnt",  retire_cnt_o, 64'd3);
    alu(1'b1, 1'b1, 5'd4, 32'h4444_4444);
    cycle();
    check("fl_st.inst", inst_o,       NOP);
    check("fl_st.ena",  reg_w_ena_o,  1'b0);
    check("fl_st.data", reg_w_data_o, 32'h0);
    check("fl_st.cnt",  retire_cnt_o, 64'd3);

    // Misaligned flag holds through a stall
    drive(1'b0, 1'b0, 32'h0000_2283, 1'b1, 32'hAAAA_5555, 32'h0000_0002, 1'b1, 32'h0, 5'd5);
    cycle();
    check("mis.flag", load_misalign_o, 1'b1);
    drive(1'b1, 1'b0, 32'h0000_0283, 1'b1, 32'hAAAA_5555, 32'h0000_0000, 1'b1, 32'h0, 5'd5);
    cycle();
    check("mis_hold.flag", load_misalign_o, 1'b1);
    check_model("mis_hold");

    // Counter wrap on the 4-bit instance: 17 real retires with NOPs between
    async_reset("wrap_rst");
    for (int i = 0; i < 17; i++) begin
      alu(1'b0, 1'b0, 5'(i + 1), 32'(i));
      cycle();
      drive(1'b0, 1'b0, NOP, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0);
      cycle();
    end
    check("wrap.cnt4", w_retire_cnt_o, 4'd1);
    check("wrap.cnt",  retire_cnt_o,   64'd17);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] inst;
      inst = ($urandom % 6 == 0) ? NOP : $urandom;
      drive(($urandom % 8) == 0, ($urandom % 10) == 0, inst, 1'($urandom),
            $urandom, $urandom, 1'($urandom),
            $urandom, ($urandom % 4 == 0) ? 5'd0 : 5'($urandom));
      cycle();
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_mem_wb
